// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall vectors,
// exception codes and the controller state encoding.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_ERET  = 32'h0000_000e;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Free-running event counter with synchronous clear; wraps modulo 2^CNT_W.
module perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)     count <= '0;
    else if (en) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, turns MEM exceptions into a
// flush plus redirect, blanks the pipe after a flush, counts stalls/flushes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          BLANK_CYCLES = 2,
  parameter int          STALL_LIMIT  = 1024,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int              CW    = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(STALL_LIMIT);

  state_e        state;
  logic [3:0]    blank_cnt;
  logic [CW-1:0] consec;
  logic          stalled;

  // Zero-latency decode: outputs are held at their reset values while rst is high
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = ZERO_WORD;
    if (!rst && state == RUN) begin
      if (excepttype_i != ZERO_WORD) begin
        flush  = 1'b1;
        new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
      end else if (stallreq_from_mem) begin
        stall = STALL_MEM;
      end else if (stallreq_from_ex) begin
        stall = STALL_EX;
      end else if (stallreq_from_id) begin
        stall = STALL_ID;
      end
    end
  end

  assign stalled = (stall != STALL_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      blank_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (flush) begin
            state     <= BLANK;
            blank_cnt <= 4'(BLANK_CYCLES - 1);
          end
        end
        BLANK: begin
          if (blank_cnt == 4'd0) state <= RUN;
          else                   blank_cnt <= blank_cnt - 4'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Watchdog: consecutive stalled cycles, saturating; flag is sticky until rst
  always_ff @(posedge clk) begin
    if (rst) begin
      consec        <= '0;
      stall_timeout <= 1'b0;
    end else if (!stalled || flush) begin
      consec <= '0;
    end else if (consec != LIMIT) begin
      consec <= consec + CW'(1);
      if (consec + CW'(1) == LIMIT) stall_timeout <= 1'b1;
    end
  end

  perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (stalled),
    .count (stall_count)
  );

  perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog limit.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  int checks   = 0;
  int failures = 0;
  int exp_scnt = 0;
  int exp_fcnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .BLANK_CYCLES (2),
    .STALL_LIMIT  (8),
    .CNT_W        (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .excepttype_i      (excepttype_i),
    .cp0_epc_i         (cp0_epc_i),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_timeout     (stall_timeout),
    .stall_count       (stall_count),
    .flush_count       (flush_count)
  );

  // inputs change 1 time unit after posedge; combinational outputs are sampled on negedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_from_id  = 1'b0;
    stallreq_from_ex  = 1'b0;
    stallreq_from_mem = 1'b0;
    excepttype_i      = 32'h0;
    cp0_epc_i         = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000) begin
      failures++; $display("FAIL reset_stall got=%b exp=%b", stall, 6'b000000);
    end
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0) begin
      failures++; $display("FAIL reset_flush got=%b/%h exp=0/00000000", flush, new_pc);
    end
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0 || stall_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d/%b exp=0/0/0", stall_count, flush_count, stall_timeout);
    end
    step();
  endtask

  task automatic test_stall_priority();
    stallreq_from_id = 1'b1;
    stallreq_from_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 6'b001111) begin
        failures++; $display("FAIL ex_over_id cyc=%0d got=%b exp=%b", i, stall, 6'b001111);
      end
      step();
      exp_scnt++;
    end
    checks++;
    if (stall_count !== 32'(exp_scnt)) begin
      failures++; $display("FAIL stall_count_3 got=%0d exp=%0d", stall_count, exp_scnt);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000) begin
      failures++; $display("FAIL stall_drop got=%b exp=%b", stall, 6'b000000);
    end
    step();
    stallreq_from_mem = 1'b1;
    stallreq_from_ex  = 1'b1;
    stallreq_from_id  = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 6'b011111) begin
      failures++; $display("FAIL mem_priority got=%b exp=%b", stall, 6'b011111);
    end
    step();
    exp_scnt++;
    stallreq_from_mem = 1'b0;
    stallreq_from_ex  = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000111) begin
      failures++; $display("FAIL id_only got=%b exp=%b", stall, 6'b000111);
    end
    step();
    exp_scnt++;
    idle_inputs();
    step();
    checks++;
    if (stall_count !== 32'(exp_scnt)) begin
      failures++; $display("FAIL stall_count_5 got=%0d exp=%0d", stall_count, exp_scnt);
    end
  endtask

  task automatic test_exception_blank();
    excepttype_i      = 32'h0000_0008;
    stallreq_from_mem = 1'b1;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || stall !== 6'b000000 || new_pc !== 32'h0000_0020) begin
      failures++;
      $display("FAIL exc_flush got=%b/%b/%h exp=1/000000/00000020", flush, stall, new_pc);
    end
    step();
    exp_fcnt++;
    checks++;
    if (flush_count !== 32'(exp_fcnt)) begin
      failures++; $display("FAIL flush_count_1 got=%0d exp=%0d", flush_count, exp_fcnt);
    end
    stallreq_from_mem = 1'b0;
    excepttype_i      = 32'h0000_000a;
    stallreq_from_id  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (flush !== 1'b0 || stall !== 6'b000000) begin
        failures++; $display("FAIL blank_mask cyc=%0d got=%b/%b exp=0/000000", i, flush, stall);
      end
      step();
    end
    excepttype_i = 32'h0;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000111 || flush !== 1'b0) begin
      failures++; $display("FAIL after_blank got=%b/%b exp=000111/0", stall, flush);
    end
    step();
    exp_scnt++;
    idle_inputs();
    step();
    checks++;
    if (stall_count !== 32'(exp_scnt) || flush_count !== 32'(exp_fcnt)) begin
      failures++;
      $display("FAIL counts_after_blank got=%0d/%0d exp=%0d/%0d", stall_count, flush_count, exp_scnt, exp_fcnt);
    end
  endtask

  task automatic test_eret();
    excepttype_i = 32'h0000_000e;
    cp0_epc_i    = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h0000_1234) begin
      failures++; $display("FAIL eret_redirect got=%b/%h exp=1/00001234", flush, new_pc);
    end
    step();
    exp_fcnt++;
    idle_inputs();
    step();
    step();
    step();
    checks++;
    if (flush_count !== 32'(exp_fcnt)) begin
      failures++; $display("FAIL flush_count_2 got=%0d exp=%0d", flush_count, exp_fcnt);
    end
  endtask

  task automatic test_watchdog();
    stallreq_from_mem = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_scnt++;
      if (i == 7) begin
        checks++;
        if (stall_timeout !== 1'b0) begin
          failures++; $display("FAIL wdog_early got=%b exp=0", stall_timeout);
        end
      end
    end
    checks++;
    if (stall_timeout !== 1'b1) begin
      failures++; $display("FAIL wdog_set got=%b exp=1", stall_timeout);
    end
    stallreq_from_mem = 1'b0;
    repeat (3) step();
    checks++;
    if (stall_timeout !== 1'b1 || stall_count !== 32'(exp_scnt)) begin
      failures++;
      $display("FAIL wdog_sticky got=%b/%0d exp=1/%0d", stall_timeout, stall_count, exp_scnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_scnt = 0;
    exp_fcnt = 0;
    checks++;
    if (stall_timeout !== 1'b0 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
      failures++;
      $display("FAIL wdog_rst got=%b/%0d/%0d exp=0/0/0", stall_timeout, stall_count, flush_count);
    end
  endtask

  task automatic test_reset_in_blank();
    excepttype_i = 32'h0000_0008;
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (flush !== 1'b0 || stall !== 6'b000000 || new_pc !== 32'h0) begin
      failures++; $display("FAIL rst_outputs got=%b/%b/%h exp=0/000000/00000000", flush, stall, new_pc);
    end
    step();
    rst = 1'b0;
    checks++;
    if (flush_count !== 32'd0 || stall_count !== 32'd0) begin
      failures++; $display("FAIL rst_blank_counts got=%0d/%0d exp=0/0", flush_count, stall_count);
    end
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h0000_0020) begin
      failures++; $display("FAIL rst_then_flush got=%b/%h exp=1/00000020", flush, new_pc);
    end
    step();
    checks++;
    if (flush_count !== 32'd1) begin
      failures++; $display("FAIL rst_then_flush_count got=%0d exp=1", flush_count);
    end
    idle_inputs();
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_exception_blank();
    test_eret();
    test_watchdog();
    test_reset_in_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
